// File: rtl/srdhm_operand_mul.sv
// Multi-cycle signed 32x32 multiplier producing {top, bottom} for the rounding-doubling high-half stage.
// Optional SRDHM_OPERAND_MUL_SAT_EN: saturate INT32_MIN*INT32_MIN and add the sat_out port.
module srdhm_operand_mul #(
  parameter int unsigned PP_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] top,
  output logic [31:0] bottom
`ifdef SRDHM_OPERAND_MUL_SAT_EN
  ,
  output logic        sat_out
`endif
);

  localparam int unsigned NCH       = 32 / PP_W;
  localparam int unsigned BEATS     = NCH * NCH;
  localparam int unsigned CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [1:0] {IDLE, ACC, FIX, DONE} state_t;

  state_t            state_q, state_d;
  logic [31:0]       a_mag_q, a_mag_d, b_mag_q, b_mag_d;
  logic              neg_q, neg_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [63:0]       acc_q, acc_d;
  logic [31:0]       top_d, bottom_d;
  logic              in_ready_d, out_valid_d;
  logic [PP_W-1:0]   a_chunk, b_chunk;
  logic [2*PP_W-1:0] pp;
  logic [63:0]       pp_shifted;
  int unsigned       ci, cj;
`ifdef SRDHM_OPERAND_MUL_SAT_EN
  logic              sat_q, sat_d, sat_out_d;
`endif

  // Chunk selection and the single shared narrow multiplier
  always_comb begin
    ci         = 32'(beat_q) % NCH;
    cj         = 32'(beat_q) / NCH;
    a_chunk    = PP_W'(a_mag_q >> (PP_W * ci));
    b_chunk    = PP_W'(b_mag_q >> (PP_W * cj));
    pp         = (2*PP_W)'(a_chunk) * (2*PP_W)'(b_chunk);
    pp_shifted = 64'(pp) << (PP_W * (ci + cj));
  end

  // Next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    a_mag_d  = a_mag_q;
    b_mag_d  = b_mag_q;
    neg_d    = neg_q;
    beat_d   = beat_q;
    acc_d    = acc_q;
    top_d    = top;
    bottom_d = bottom;
`ifdef SRDHM_OPERAND_MUL_SAT_EN
    sat_d     = sat_q;
    sat_out_d = sat_out;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          // Two's-complement magnitude; INT_MIN maps to 0x80000000 unsigned
          a_mag_d = in_a[31] ? (~in_a + 32'd1) : in_a;
          b_mag_d = in_b[31] ? (~in_b + 32'd1) : in_b;
          neg_d   = in_a[31] ^ in_b[31];
          beat_d  = '0;
          acc_d   = '0;
`ifdef SRDHM_OPERAND_MUL_SAT_EN
          sat_d   = (in_a == INT_MIN) && (in_b == INT_MIN);
`endif
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d  = acc_q + pp_shifted;
        beat_d = beat_q + CNT_W'(1);
        if (beat_q == LAST_BEAT) state_d = FIX;
      end
      FIX: begin
        {top_d, bottom_d} = neg_q ? (~acc_q + 64'd1) : acc_q;
`ifdef SRDHM_OPERAND_MUL_SAT_EN
        if (sat_q) {top_d, bottom_d} = 64'h3FFF_FFFF_8000_0000;
        sat_out_d = sat_q;
`endif
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      a_mag_q   <= '0;
      b_mag_q   <= '0;
      neg_q     <= 1'b0;
      beat_q    <= '0;
      acc_q     <= '0;
      top       <= '0;
      bottom    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
`ifdef SRDHM_OPERAND_MUL_SAT_EN
      sat_q     <= 1'b0;
      sat_out   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_mag_q   <= a_mag_d;
      b_mag_q   <= b_mag_d;
      neg_q     <= neg_d;
      beat_q    <= beat_d;
      acc_q     <= acc_d;
      top       <= top_d;
      bottom    <= bottom_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
`ifdef SRDHM_OPERAND_MUL_SAT_EN
      sat_q     <= sat_d;
      sat_out   <= sat_out_d;
`endif
    end
  end

endmodule

// File: doc/srdhm_operand_mul.md
Name: srdhm_operand_mul

Overview:
- Multi-cycle signed 32x32 multiplier that produces the 64-bit product split into {top, bottom}.
- Its outputs feed the rounding/doubling high-half stage of the requantization path directly: top = product[63:32], bottom = product[31:0].
- Uses a valid/ready handshake on both sides and a single narrow unsigned multiplier reused across beats, so DSP usage stays at one slice.
- Sits between the accumulator/multiplier-register file and the high-half rounding stage.

Parameters:
- PP_W, 16, partial-product operand width. Legal values: 8, 16, 32. BEATS = (32/PP_W)^2, giving 16, 4 or 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- in_a  in  32  signed operand (accumulator value)
- in_b  in  32  signed operand (quantized multiplier)
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- top  out  32  product[63:32]
- bottom  out  32  product[31:0]

Behaviour:
- Decided: one clock, clk. Reset is synchronous and active-high, port named reset.
- FSM states: IDLE, ACC, FIX, DONE.
- Reset, including mid-operation:
  - state=IDLE, beat counter=0, accumulator=0.
  - top=0, bottom=0, out_valid=0, in_ready=1 on the next cycle.
  - Any in-flight operation is discarded, with no partial output.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready (edge E0), register:
    - |in_a| and |in_b| as 32-bit unsigned. |0x80000000| = 0x80000000, no overflow.
    - neg = in_a[31]^in_b[31].
  - Clear the 64-bit accumulator and go to ACC.
- ACC: one beat per cycle, beats E1..E_BEATS.
  - Beat k selects magnitude chunks a_i, b_j (PP_W bits each; i = k mod (32/PP_W), j = k div (32/PP_W)).
  - acc += (a_i*b_j) << (PP_W*(i+j)).
  - Accumulation is unsigned 64-bit. No carry beyond bit 63 is possible.
  - After the last beat go to FIX.
- FIX: one cycle, edge E_BEATS+1.
  - {top,bottom} <= neg ? -acc : acc (two's complement, 64-bit).
  - Set out_valid=1 and go to DONE.
- DONE:
  - out_valid=1. top and bottom are stable until the handshake.
  - On out_ready go to IDLE and drop out_valid. top and bottom hold their last value.
- in_ready is 1 only in IDLE. in_valid seen in ACC, FIX or DONE is ignored; the upstream holds it.
- Latency: out_valid rises BEATS+1 cycles after the accepting edge (5 for PP_W=16).
- Throughput: one operation per BEATS+3 cycles when out_ready is held high.
- Operands are captured at accept. Later changes to in_a or in_b have no effect.
- out_ready while out_valid=0 is ignored.
- Zero operand: product 0 and top=bottom=0. A negative zero is never produced (-0 = 0).

Optional Feature:
- Macro: SRDHM_OPERAND_MUL_SAT_EN.
- Defined:
  - At accept, flag sat = (in_a==0x80000000 && in_b==0x80000000).
  - In FIX, when sat=1, force {top,bottom} = 0x3FFFFFFF_80000000 instead of 0x40000000_00000000. The downstream nudge-and-shift-by-31 stage then yields 0x7FFFFFFF, matching saturating-rounding-doubling-high-mul semantics.
  - A 1-bit output port sat_out is added. It is registered, valid while out_valid=1, and reset to 0.
- Not defined:
  - The raw product is always emitted and there is no sat_out port.
  - For INT32_MIN*INT32_MIN the downstream result wraps to 0x80000000. This is the documented limitation.

Test Plan:
- Reset then in_a=3, in_b=-5, out_ready=1 -> out_valid exactly 5 cycles after accept (PP_W=16); top=0xFFFFFFFF, bottom=0xFFFFFFF1; in_ready low until DONE handshake.
- in_a=0x7FFFFFFF, in_b=0x7FFFFFFF -> top=0x3FFFFFFF, bottom=0x00000001. Repeat with PP_W=8 and PP_W=32: identical result, latency 17 and 2 respectively.
- in_a=0x80000000, in_b=0x80000000 -> without macro top=0x40000000, bottom=0; with SRDHM_OPERAND_MUL_SAT_EN top=0x3FFFFFFF, bottom=0x80000000, sat_out=1.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> top, bottom and out_valid stable, in_valid ignored; release -> IDLE next cycle, next op accepted one cycle later.
- reset asserted during the ACC beat 2 of op 0x1234*0x5678 -> next cycle out_valid=0, in_ready=1, top=bottom=0. Next op -7*-9 -> bottom=0x3F, top=0.
- Random 10k signed pairs with random in_valid/out_ready stalls -> every result matches the 64-bit signed reference product. No lost or duplicated transactions (scoreboard count equality).
